// File: rtl/enemy_bullet_ctrl_pkg.sv
// Shared game definitions: screen geometry, coordinate type and the bullet
// FSM state encoding used by the enemy/player bullet controllers and the judge.
package enemy_bullet_ctrl_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FLY    = 2'd1;
  localparam state_t ST_RELOAD = 2'd2;

  // Spawn coordinate: base plus offset, wrapping within the coordinate width.
  function automatic coord_t spawn_pos(input coord_t base, input int ofs);
    return base + coord_t'(ofs);
  endfunction

endpackage

// File: rtl/enemy_bullet_ctrl_if.sv
// Enemy-bullet bus: enemy muzzle inputs and hit feedback in, bullet state out.
// The controller uses the master modport; the judge/environment uses slave.
interface enemy_bullet_ctrl_if;
  import enemy_bullet_ctrl_pkg::*;

  coord_t enemy_x;
  coord_t enemy_y;
  logic   enemy_en;
  logic   hit;
  coord_t eb_x;
  coord_t eb_y;
  logic   enemy_bullet_en;
  logic   fire;

  modport master (
    input  enemy_x, enemy_y, enemy_en, hit,
    output eb_x, eb_y, enemy_bullet_en, fire
  );

  modport slave (
    output enemy_x, enemy_y, enemy_en, hit,
    input  eb_x, eb_y, enemy_bullet_en, fire
  );

endinterface

// File: rtl/enemy_bullet_ctrl_tick_gen.sv
// Free-running divider: tick is high for the single cycle the counter sits at
// DIV-1, after which the counter wraps to zero.
module enemy_bullet_ctrl_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/enemy_bullet_ctrl.sv
// Single enemy bullet: spawns at the enemy muzzle, falls STEP pixels per move
// tick, retires on screen exit or hit, then reloads for RELOAD_TICKS ticks.
module enemy_bullet_ctrl
  import enemy_bullet_ctrl_pkg::*;
#(
  parameter int SCREEN_H     = enemy_bullet_ctrl_pkg::SCREEN_H,
  parameter int STEP         = 4,
  parameter int TICK_DIV     = 100000,
  parameter int RELOAD_TICKS = 50,
  parameter int X_OFS        = 20,
  parameter int Y_OFS        = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  enemy_bullet_ctrl_if.master bus
);

  localparam int RW = (RELOAD_TICKS > 0) ? $clog2(RELOAD_TICKS + 1) : 1;

  state_t          state;
  coord_t          eb_x;
  coord_t          eb_y;
  logic            eb_en;
  logic            fire;
  logic [RW-1:0]   rcnt;
  logic [RW-1:0]   rcnt_next;
  logic            tick;
  coord_t          spawn_x;
  coord_t          spawn_y;
  logic [COORD_W:0] ny;
  logic            off_screen;
  logic            reload_done;

  enemy_bullet_ctrl_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign spawn_x     = spawn_pos(bus.enemy_x, X_OFS);
  assign spawn_y     = spawn_pos(bus.enemy_y, Y_OFS);
  // One extra bit so a bullet near the bottom cannot wrap back to the top.
  assign ny          = {1'b0, eb_y} + (COORD_W+1)'(STEP);
  assign off_screen  = (ny >= (COORD_W+1)'(SCREEN_H));
  assign rcnt_next   = rcnt + RW'(1);
  assign reload_done = (rcnt_next == RW'(RELOAD_TICKS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      eb_x  <= '0;
      eb_y  <= '0;
      eb_en <= 1'b0;
      fire  <= 1'b0;
      rcnt  <= '0;
    end else begin
      fire <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.enemy_en) begin
            state <= ST_FLY;
            eb_x  <= spawn_x;
            eb_y  <= spawn_y;
            eb_en <= 1'b1;
            fire  <= 1'b1;
          end
        end
        ST_FLY: begin
          if (bus.hit) begin
            state <= ST_RELOAD;
            eb_en <= 1'b0;
            rcnt  <= '0;
          end else if (tick) begin
            if (off_screen) begin
              state <= ST_RELOAD;
              eb_en <= 1'b0;
              rcnt  <= '0;
            end else begin
              eb_y <= ny[COORD_W-1:0];
            end
          end
        end
        ST_RELOAD: begin
          if (tick) begin
            if (reload_done) begin
              rcnt <= '0;
              if (bus.enemy_en) begin
                state <= ST_FLY;
                eb_x  <= spawn_x;
                eb_y  <= spawn_y;
                eb_en <= 1'b1;
                fire  <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              rcnt <= rcnt_next;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          eb_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.eb_x            = eb_x;
  assign bus.eb_y            = eb_y;
  assign bus.enemy_bullet_en = eb_en;
  assign bus.fire            = fire;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Directed bench for enemy_bullet_ctrl with TICK_DIV=4, STEP=4, RELOAD_TICKS=2,
// X_OFS=20, Y_OFS=40, SCREEN_H=480; expected values are worked out by hand.
module tb_enemy_bullet_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pcount = 0;
  int   fire_cnt;
  int   en_cnt;
  logic found;

  enemy_bullet_ctrl_if bus ();

  enemy_bullet_ctrl #(
    .SCREEN_H     (480),
    .STEP         (4),
    .TICK_DIV     (4),
    .RELOAD_TICKS (2),
    .X_OFS        (20),
    .Y_OFS        (40)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counts rising edges since reset release; every 4th edge carries a move tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcount <= 0;
    else        pcount <= pcount + 1;
  end

  task automatic apply_stimulus(input int x, input int y, input logic en, input logic h);
    bus.enemy_x  = 10'(x);
    bus.enemy_y  = 10'(y);
    bus.enemy_en = en;
    bus.hit      = h;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_to_tick();
    do @(negedge clk); while (pcount % 4 != 0);
  endtask

  initial begin
    apply_stimulus(100, 50, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    check_output("rst_eb_x", 32'(bus.eb_x), 0);
    check_output("rst_eb_y", 32'(bus.eb_y), 0);
    check_output("rst_en", 32'(bus.enemy_bullet_en), 0);
    check_output("rst_fire", 32'(bus.fire), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] spawn after reset release");
    @(negedge clk);
    check_output("t1_fire", 32'(bus.fire), 1);
    check_output("t1_eb_x", 32'(bus.eb_x), 120);
    check_output("t1_eb_y", 32'(bus.eb_y), 90);
    check_output("t1_en", 32'(bus.enemy_bullet_en), 1);
    @(negedge clk);
    check_output("t1_fire_pulse", 32'(bus.fire), 0);
    check_output("t1_eb_y_hold", 32'(bus.eb_y), 90);
    step_to_tick();
    check_output("t1_eb_y_tick1", 32'(bus.eb_y), 94);
    step_to_tick();
    check_output("t1_eb_y_tick2", 32'(bus.eb_y), 98);
    check_output("t1_en_fly", 32'(bus.enemy_bullet_en), 1);

    $display("[TB] hit coincident with tick");
    repeat (3) @(negedge clk);
    bus.hit = 1'b1;
    @(negedge clk);
    check_output("t3_en", 32'(bus.enemy_bullet_en), 0);
    check_output("t3_eb_y", 32'(bus.eb_y), 98);
    check_output("t3_fire", 32'(bus.fire), 0);
    bus.hit = 1'b0;
    bus.enemy_y = 10'd430;
    step_to_tick();
    check_output("t3_reload_en", 32'(bus.enemy_bullet_en), 0);
    check_output("t3_reload_fire", 32'(bus.fire), 0);
    step_to_tick();
    check_output("t2_spawn_fire", 32'(bus.fire), 1);
    check_output("t2_spawn_x", 32'(bus.eb_x), 120);
    check_output("t2_spawn_y", 32'(bus.eb_y), 470);
    check_output("t2_spawn_en", 32'(bus.enemy_bullet_en), 1);

    $display("[TB] flight to bottom");
    apply_stimulus(200, 100, 1'b1, 1'b0);
    step_to_tick();
    check_output("t2_y474", 32'(bus.eb_y), 474);
    step_to_tick();
    check_output("t2_y478", 32'(bus.eb_y), 478);
    step_to_tick();
    check_output("t2_exit_en", 32'(bus.enemy_bullet_en), 0);
    check_output("t2_exit_y", 32'(bus.eb_y), 478);
    step_to_tick();
    check_output("t2_reload_fire", 32'(bus.fire), 0);
    step_to_tick();
    check_output("t2_respawn_fire", 32'(bus.fire), 1);
    check_output("t2_respawn_x", 32'(bus.eb_x), 220);
    check_output("t2_respawn_y", 32'(bus.eb_y), 140);

    $display("[TB] reload expiry with enemy disabled");
    @(negedge clk);
    bus.hit = 1'b1;
    @(negedge clk);
    check_output("t4_hit_en", 32'(bus.enemy_bullet_en), 0);
    check_output("t4_hit_y", 32'(bus.eb_y), 140);
    apply_stimulus(200, 100, 1'b0, 1'b0);
    step_to_tick();
    step_to_tick();
    check_output("t4_expire_fire", 32'(bus.fire), 0);
    check_output("t4_expire_en", 32'(bus.enemy_bullet_en), 0);
    repeat (2) @(negedge clk);
    check_output("t4_idle_en", 32'(bus.enemy_bullet_en), 0);
    apply_stimulus(300, 200, 1'b1, 1'b0);
    @(negedge clk);
    check_output("t4_spawn_fire", 32'(bus.fire), 1);
    check_output("t4_spawn_x", 32'(bus.eb_x), 320);
    check_output("t4_spawn_y", 32'(bus.eb_y), 240);
    check_output("t4_spawn_en", 32'(bus.enemy_bullet_en), 1);

    $display("[TB] asynchronous reset mid-flight");
    @(negedge clk);
    check_output("t5_pre_y", 32'(bus.eb_y), 244);
    #2 rst_n = 1'b0;
    #1;
    check_output("t5_rst_x", 32'(bus.eb_x), 0);
    check_output("t5_rst_y", 32'(bus.eb_y), 0);
    check_output("t5_rst_en", 32'(bus.enemy_bullet_en), 0);
    check_output("t5_rst_fire", 32'(bus.fire), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fire_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_output("t5_spawn_y", 32'(bus.eb_y), 240);
        check_output("t5_spawn_en", 32'(bus.enemy_bullet_en), 1);
        bus.enemy_en = 1'b0;
      end
      if (bus.fire) fire_cnt++;
    end
    check_output("t5_fire_count", 32'(fire_cnt), 1);

    $display("[TB] enemy disabled during flight");
    check_output("t6_cont_y", 32'(bus.eb_y), 248);
    check_output("t6_cont_en", 32'(bus.enemy_bullet_en), 1);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.enemy_bullet_en) begin
        found = 1'b1;
        break;
      end
    end
    check_output("t6_retired", 32'(found), 1);
    check_output("t6_last_y", 32'(bus.eb_y), 476);
    check_output("t6_x_const", 32'(bus.eb_x), 320);
    fire_cnt = 0;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fire) fire_cnt++;
      if (bus.enemy_bullet_en) en_cnt++;
    end
    check_output("t6_no_respawn_fire", 32'(fire_cnt), 0);
    check_output("t6_no_respawn_en", 32'(en_cnt), 0);

    $display("[TB] spawn below screen and x wrap");
    apply_stimulus(1010, 450, 1'b1, 1'b0);
    @(negedge clk);
    check_output("t7_fire", 32'(bus.fire), 1);
    check_output("t7_x_wrap", 32'(bus.eb_x), 6);
    check_output("t7_y", 32'(bus.eb_y), 490);
    check_output("t7_en", 32'(bus.enemy_bullet_en), 1);
    step_to_tick();
    check_output("t7_retire_en", 32'(bus.enemy_bullet_en), 0);
    check_output("t7_retire_y", 32'(bus.eb_y), 490);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
